// File: rtl/ipf_lcu_feeder_pkg.sv
// Shared constants, field positions and state types for ipf_lcu_feeder.
// Build option IPF_FEEDER_RASTER_EN selects raster-ordered image addressing.
package ipf_pkg;

   localparam int IMG_W  = 128;
   localparam int AW     = $clog2(IMG_W * IMG_W);
   localparam int PAR_W  = 24;

   localparam int PT_MSB = 23;
   localparam int PT_LSB = 22;
   localparam int BP_MSB = 21;
   localparam int BP_LSB = 17;
   localparam int WO_BIT = 16;
   localparam int OF_MSB = 15;
   localparam int OF_LSB = 0;

   typedef enum logic [1:0] {
      SZ_16,
      SZ_32,
      SZ_64,
      SZ_RSV
   } lcu_sz_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STREAM
   } state_e;

   // The reserved code walks the frame exactly like the 64x64 code.
   function automatic logic [1:0] eff_code(input logic [1:0] c);
      return (c == SZ_RSV) ? SZ_64 : c;
   endfunction

endpackage

// File: rtl/ipf_lcu_feeder_if.sv
// Pixel stream and per-LCU side channel from the feeder into IPF.
// Master drives pixels/parameters; slave returns back-pressure.
interface ipf_lcu_feeder_if;

   logic        in_en;
   logic        busy;
   logic [7:0]  din;
   logic [1:0]  ipf_type;
   logic [4:0]  ipf_band_pos;
   logic        ipf_wo_class;
   logic [15:0] ipf_offset;
   logic [2:0]  lcu_x;
   logic [2:0]  lcu_y;
   logic [1:0]  lcu_size;

   modport master (
      output in_en, din, ipf_type, ipf_band_pos, ipf_wo_class,
      output ipf_offset, lcu_x, lcu_y, lcu_size,
      input  busy
   );

   modport slave (
      input  in_en, din, ipf_type, ipf_band_pos, ipf_wo_class,
      input  ipf_offset, lcu_x, lcu_y, lcu_size,
      output busy
   );

endinterface

// File: rtl/ipf_lcu_feeder_fifo.sv
// Two-entry pixel skid buffer between the image memory and the IPF port.
module ipf_feed_fifo (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_clr,
   input  logic       i_push,
   input  logic [7:0] i_data,
   input  logic       i_pop,
   output logic [7:0] o_data,
   output logic       o_ne,
   output logic [1:0] o_occ
);

   logic [1:0][7:0] r_mem;
   logic            r_wp;
   logic            r_rp;
   logic [1:0]      r_cnt;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_mem <= '0;
         r_wp  <= 1'b0;
         r_rp  <= 1'b0;
         r_cnt <= 2'd0;
      end else if (i_clr) begin
         r_wp  <= 1'b0;
         r_rp  <= 1'b0;
         r_cnt <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wp] <= i_data;
            r_wp        <= ~r_wp;
         end
         if (i_pop)
            r_rp <= ~r_rp;
         r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   assign o_data = r_mem[r_rp];
   assign o_ne   = (r_cnt != 2'd0);
   assign o_occ  = r_cnt;

endmodule

// File: rtl/ipf_lcu_feeder.sv
// Walks a 128x128 frame LCU by LCU and streams pixels plus parameters into IPF.
// IPF_FEEDER_RASTER_EN: raster image layout; default: LCU-contiguous layout.
module ipf_lcu_feeder
   import ipf_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [1:0]       i_cfg_lcu_size,
   output logic             o_img_rd,
   output logic [AW-1:0]    o_img_addr,
   input  logic [7:0]       i_img_data,
   output logic             o_par_rd,
   output logic [5:0]       o_par_addr,
   input  logic [PAR_W-1:0] i_par_data,
   output logic             o_active,
   output logic             o_done,
   ipf_lcu_feeder_if.master ipf
);

   state_e        r_state;
   state_e        w_nxt;
   logic [1:0]    r_code;
   logic [5:0]    r_n;
   logic [12:0]   r_rd_cnt;
   logic [11:0]   r_pop_cnt;
   logic          r_inflight;
   logic          r_first;
   logic          r_done;
   logic [2:0]    r_lcu_x;
   logic [2:0]    r_lcu_y;
   logic [1:0]    r_type;
   logic [4:0]    r_band;
   logic          r_wo;
   logic [15:0]   r_off;

   logic [1:0]    w_c;
   logic [2:0]    w_lg;
   logic [2:0]    w_lgb;
   logic [2:0]    w_x;
   logic [2:0]    w_y;
   logic [5:0]    w_nb_m1;
   logic [11:0]   w_sq_m1;
   logic [11:0]   w_idx;
   logic [AW-1:0] w_addr;
   logic [1:0]    w_occ;
   logic [2:0]    w_lvl;
   logic [7:0]    w_dout;
   logic          w_ne;
   logic          w_pop;
   logic          w_more;
   logic          w_last;
   logic          w_end;
   logic          w_go;
   logic          w_rd;
   logic          w_prd;
   logic          w_acc_last;

   assign w_c     = eff_code(r_code);
   assign w_lg    = 3'd4 + {1'b0, w_c};
   assign w_lgb   = 3'd3 - {1'b0, w_c};
   assign w_nb_m1 = 6'h3f >> {w_c, 1'b0};
   assign w_sq_m1 = 12'hfff >> (3'd4 - {w_c, 1'b0});
   assign w_x     = r_n[2:0] & (3'h7 >> w_c);
   assign w_y     = 3'(r_n >> w_lgb);

   assign w_pop  = w_ne & ~ipf.busy;
   assign w_last = (r_pop_cnt == w_sq_m1);
   assign w_end  = (r_n == w_nb_m1);
   assign w_more = (r_rd_cnt <= {1'b0, w_sq_m1});
   assign w_lvl  = {1'b0, w_occ} + {2'b0, r_inflight};
   assign w_idx  = (r_state == ST_LOAD) ? 12'd0 : r_rd_cnt[11:0];

`ifdef IPF_FEEDER_RASTER_EN
   logic [AW-1:0] w_py;
   logic [AW-1:0] w_px;
   assign w_py   = AW'(w_idx >> w_lg);
   assign w_px   = AW'(w_idx) & ((AW'(1) << w_lg) - AW'(1));
   assign w_addr = ((AW'(w_y) << w_lg) + w_py) * AW'(IMG_W)
                 + (AW'(w_x) << w_lg) + w_px;
`else
   logic [3:0] w_lg2;
   assign w_lg2  = {w_lg, 1'b0};
   assign w_addr = (AW'(r_n) << w_lg2) + AW'(w_idx);
`endif

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_nxt;
   end

   always_comb begin
      w_nxt      = r_state;
      w_go       = 1'b0;
      w_rd       = 1'b0;
      w_prd      = 1'b0;
      w_acc_last = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            // A start coinciding with the done cycle is dropped.
            if (i_start && !r_done) begin
               w_go  = 1'b1;
               w_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            w_prd = 1'b1;
            w_rd  = 1'b1;
            w_nxt = ST_STREAM;
         end
         ST_STREAM: begin
            w_rd = w_more && (w_lvl < 3'd2 + {2'b0, w_pop});
            if (w_pop && w_last) begin
               w_acc_last = 1'b1;
               w_nxt      = w_end ? ST_IDLE : ST_LOAD;
            end
         end
         default: w_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_code     <= 2'd0;
         r_n        <= 6'd0;
         r_rd_cnt   <= 13'd0;
         r_pop_cnt  <= 12'd0;
         r_inflight <= 1'b0;
         r_first    <= 1'b0;
         r_done     <= 1'b0;
         r_lcu_x    <= 3'd0;
         r_lcu_y    <= 3'd0;
         r_type     <= 2'd0;
         r_band     <= 5'd0;
         r_wo       <= 1'b0;
         r_off      <= 16'd0;
      end else begin
         r_inflight <= w_rd;
         r_first    <= (r_state == ST_LOAD);
         r_done     <= w_acc_last & w_end;
         if (w_go) begin
            r_code <= i_cfg_lcu_size;
            r_n    <= 6'd0;
         end else if (w_acc_last && !w_end) begin
            r_n <= r_n + 6'd1;
         end
         if (r_state == ST_LOAD) begin
            r_rd_cnt  <= 13'd1;
            r_pop_cnt <= 12'd0;
         end else begin
            if (w_rd)
               r_rd_cnt <= r_rd_cnt + 13'd1;
            if (w_pop)
               r_pop_cnt <= r_pop_cnt + 12'd1;
         end
         if (r_first) begin
            r_type  <= i_par_data[PT_MSB:PT_LSB];
            r_band  <= i_par_data[BP_MSB:BP_LSB];
            r_wo    <= i_par_data[WO_BIT];
            r_off   <= i_par_data[OF_MSB:OF_LSB];
            r_lcu_x <= w_x;
            r_lcu_y <= w_y;
         end
      end
   end

   ipf_feed_fifo u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (w_go),
      .i_push  (r_inflight),
      .i_data  (i_img_data),
      .i_pop   (w_pop),
      .o_data  (w_dout),
      .o_ne    (w_ne),
      .o_occ   (w_occ)
   );

   assign o_img_rd   = w_rd;
   assign o_img_addr = w_rd ? w_addr : '0;
   assign o_par_rd   = w_prd;
   assign o_par_addr = w_prd ? r_n : 6'd0;
   assign o_active   = (r_state != ST_IDLE) | r_done;
   assign o_done     = r_done;

   assign ipf.in_en        = w_ne;
   assign ipf.din          = w_dout;
   assign ipf.ipf_type     = r_type;
   assign ipf.ipf_band_pos = r_band;
   assign ipf.ipf_wo_class = r_wo;
   assign ipf.ipf_offset   = r_off;
   assign ipf.lcu_x        = r_lcu_x;
   assign ipf.lcu_y        = r_lcu_y;
   assign ipf.lcu_size     = r_code;

endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Directed bench for ipf_lcu_feeder: frame walks, stalls, reset abort.
module tb_ipf_lcu_feeder;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  cfg;
   logic        img_rd;
   logic [13:0] img_addr;
   logic [7:0]  img_data;
   logic        par_rd;
   logic [5:0]  par_addr;
   logic [23:0] par_data;
   logic        active;
   logic        done;

   int n_chk;
   int n_err;
   int s_beats, s_dinbad, s_sidebad, s_stallbad, s_gapbad;
   int s_parbad, s_npar, s_dones, s_ovfbad, s_reads, s_cycles;
   int s_hold_reads, s_hold_diff, s_actbad;

   ipf_lcu_feeder_if ifc ();

   ipf_lcu_feeder dut (
      .i_clk          (clk),
      .i_reset        (rst_n),
      .i_start        (start),
      .i_cfg_lcu_size (cfg),
      .o_img_rd       (img_rd),
      .o_img_addr     (img_addr),
      .i_img_data     (img_data),
      .o_par_rd       (par_rd),
      .o_par_addr     (par_addr),
      .i_par_data     (par_data),
      .o_active       (active),
      .o_done         (done),
      .ipf            (ifc.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] img_f(input int a);
      return 8'(a ^ (a >> 8));
   endfunction

   function automatic logic [23:0] par_word(input int n);
      return 24'hC21234 ^ (24'(n) << 18) ^ 24'(n * 257);
   endfunction

   function automatic int exp_addr(input int ce, input int lcu, input int idx);
      int s;
      int nb;
      s  = 16 << ce;
      nb = 128 / s;
`ifdef IPF_FEEDER_RASTER_EN
      return ((lcu / nb) * s + idx / s) * 128 + (lcu % nb) * s + idx % s;
`else
      return lcu * s * s + idx;
`endif
   endfunction

   always @(posedge clk) begin
      if (img_rd) img_data <= img_f(int'(img_addr));
      if (par_rd) par_data <= par_word(int'(par_addr));
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // mode 0: busy low; 1: random busy; 2: one 10-cycle busy hold at beat 100
   task automatic run_frame(input int code, input int mode, input int stop_at);
      int ce, s, sq, nb, cyc, lowrun, hcnt, lcu, idx;
      logic pstall;
      logic [7:0] pdin;
      logic [23:0] pw;
      ce = (code == 3) ? 2 : code;
      s  = 16 << ce;
      sq = s * s;
      nb = 128 / s;
      s_beats = 0; s_dinbad = 0; s_sidebad = 0; s_stallbad = 0;
      s_gapbad = 0; s_parbad = 0; s_npar = 0; s_dones = 0;
      s_ovfbad = 0; s_reads = 0; s_cycles = 0; s_actbad = 0;
      s_hold_reads = 0; s_hold_diff = -1;
      cyc = 0; lowrun = 0; hcnt = 0; pstall = 1'b0; pdin = 8'd0;
      @(negedge clk);
      start = 1'b1;
      cfg   = code[1:0];
      while (cyc < 60000 && s_dones == 0 &&
             (stop_at == 0 || s_beats < stop_at)) begin
         @(negedge clk);
         start = 1'b0;
         if (mode == 1)
            ifc.busy = 1'($urandom_range(0, 1));
         else if (mode == 2 && s_beats >= 100 && hcnt < 10) begin
            ifc.busy = 1'b1;
            hcnt++;
         end else
            ifc.busy = 1'b0;
         #1;
         if (cyc == 0 && !active) s_actbad++;
         if (par_rd) begin
            if (int'(par_addr) != s_npar) s_parbad++;
            s_npar++;
         end
         if (img_rd) begin
            s_reads++;
            if (mode == 2 && ifc.busy) s_hold_reads++;
         end
         if (pstall && (!ifc.in_en || ifc.din !== pdin)) s_stallbad++;
         if (ifc.in_en) begin
            lcu = s_beats / sq;
            idx = s_beats % sq;
            if (idx == 0 && s_beats > 0 && mode != 1 && lowrun != 2)
               s_gapbad++;
            lowrun = 0;
            if (ifc.din !== img_f(exp_addr(ce, lcu, idx))) s_dinbad++;
            pw = par_word(lcu);
            if (ifc.lcu_x !== 3'(lcu % nb) || ifc.lcu_y !== 3'(lcu / nb) ||
                ifc.lcu_size !== code[1:0] ||
                ifc.ipf_type !== pw[23:22] ||
                ifc.ipf_band_pos !== pw[21:17] ||
                ifc.ipf_wo_class !== pw[16] ||
                ifc.ipf_offset !== pw[15:0])
               s_sidebad++;
            if (!ifc.busy) s_beats++;
         end else begin
            lowrun++;
         end
         pstall = ifc.in_en & ifc.busy;
         pdin   = ifc.din;
         if (s_reads - s_beats > 2) s_ovfbad++;
         if (mode == 2 && hcnt == 10 && ifc.busy)
            s_hold_diff = s_reads - s_beats;
         if (done) begin
            s_dones++;
            s_cycles = cyc;
         end
         cyc++;
      end
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      start = 1'b0;
      cfg   = 2'd0;
      ifc.busy = 1'b0;
      #12;
      chk("reset_mem_side", {img_rd, img_addr, par_rd, par_addr, active, done}, 0);
      chk("reset_ipf_side", {ifc.in_en, ifc.din, ifc.ipf_type, ifc.ipf_band_pos,
          ifc.ipf_wo_class, ifc.ipf_offset, ifc.lcu_x, ifc.lcu_y, ifc.lcu_size}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // code 2, no back-pressure
      run_frame(2, 0, 0);
      chk("c2_beats", s_beats, 16384);
      chk("c2_din_bad", s_dinbad, 0);
      chk("c2_side_bad", s_sidebad, 0);
      chk("c2_gap_bad", s_gapbad, 0);
      chk("c2_done_cnt", s_dones, 1);
      chk("c2_cycles", s_cycles, 16392);
      chk("c2_reads", s_reads, 16384);
      chk("c2_ovf_bad", s_ovfbad, 0);
      chk("c2_par_cnt", s_npar, 4);
      chk("c2_par_bad", s_parbad, 0);
      chk("c2_active_load", s_actbad, 0);
      start = 1'b1;
      cfg   = 2'd2;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("start_on_done_ignored", active, 0);
      chk("done_single_pulse", done, 0);

      // code 0 with one long stall
      run_frame(0, 2, 0);
      chk("c0_beats", s_beats, 16384);
      chk("c0_din_bad", s_dinbad, 0);
      chk("c0_side_bad", s_sidebad, 0);
      chk("c0_gap_bad", s_gapbad, 0);
      chk("c0_done_cnt", s_dones, 1);
      chk("c0_par_cnt", s_npar, 64);
      chk("c0_par_bad", s_parbad, 0);
      chk("c0_hold_reads", s_hold_reads, 0);
      chk("c0_hold_buffered", s_hold_diff, 2);
      chk("c0_ovf_bad", s_ovfbad, 0);
      chk("c0_last_x", ifc.lcu_x, 7);
      chk("c0_last_y", ifc.lcu_y, 7);

      // code 3 under random back-pressure
      run_frame(3, 1, 0);
      chk("c3_beats", s_beats, 16384);
      chk("c3_din_bad", s_dinbad, 0);
      chk("c3_side_bad", s_sidebad, 0);
      chk("c3_stall_bad", s_stallbad, 0);
      chk("c3_done_cnt", s_dones, 1);
      chk("c3_reads", s_reads, 16384);
      chk("c3_ovf_bad", s_ovfbad, 0);
      chk("c3_lcu_size", ifc.lcu_size, 3);
      @(negedge clk);
      ifc.busy = 1'b0;

      // reset pulled mid LCU 1, then restart
      run_frame(2, 0, 4096 + 50);
      chk("abort_reached", s_beats, 4146);
      rst_n = 1'b0;
      #1;
      chk("abort_mem_side", {img_rd, img_addr, par_rd, par_addr, active, done}, 0);
      chk("abort_ipf_side", {ifc.in_en, ifc.din, ifc.ipf_type, ifc.ipf_band_pos,
          ifc.ipf_wo_class, ifc.ipf_offset, ifc.lcu_x, ifc.lcu_y, ifc.lcu_size}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(2, 0, 300);
      chk("restart_beats", s_beats, 300);
      chk("restart_din_bad", s_dinbad, 0);
      chk("restart_side_bad", s_sidebad, 0);
      chk("restart_par_addr", s_parbad, 0);
      chk("restart_type", ifc.ipf_type, 3);
      chk("restart_band", ifc.ipf_band_pos, 1);
      chk("restart_wo", ifc.ipf_wo_class, 0);
      chk("restart_offset", ifc.ipf_offset, 16'h1234);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ipf_lcu_feeder.md
# ipf_lcu_feeder

Hardware stimulus source for the IPF filter input port. On `start` it walks a 128×128 8-bit image LCU by LCU, reading pixels from a synchronous-read image memory and per-LCU filter parameters from a parameter table. It streams pixels into IPF with the `in_en`/`busy` handshake while driving `lcu_x`, `lcu_y`, `lcu_size` and the IPF parameter fields. It replaces the behavioural pixel driver in system-level simulation and in FPGA bring-up.

## Interface
- `IMG_W`, 128: image width and height in pixels; fixed square image.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: begin a frame; sampled only in IDLE.
- `cfg_lcu_size` in 2: LCU size code. 0 = 16, 1 = 32, 2 = 64, 3 = reserved (treated as 2). Latched on `start`.
- `img_rd` out 1: image memory read strobe.
- `img_addr` out 14: image memory address.
- `img_data` in 8: image memory data, valid in the cycle after `img_rd`.
- `par_rd` out 1: parameter table read strobe.
- `par_addr` out 6: parameter table address, equal to the LCU index n.
- `par_data` in 24: parameter word, valid in the cycle after `par_rd`. Fields: [23:22] type, [21:17] band_pos, [16] wo_class, [15:0] offset.
- `busy` in 1: IPF back-pressure.
- `in_en` out 1: pixel valid to IPF.
- `din` out 8: pixel.
- `ipf_type` out 2, `ipf_band_pos` out 5, `ipf_wo_class` out 1, `ipf_offset` out 16: parameters of the current LCU.
- `lcu_x`, `lcu_y` out 3 each: LCU column and row.
- `lcu_size` out 2: latched size code.
- `active` out 1: frame in progress.
- `done` out 1: one-cycle pulse after the last pixel is accepted.

## Operation
- Let S = 16 << code and B = 128 / S.
- LCU order: n = 0 .. B²−1, with `lcu_x` = n mod B and `lcu_y` = n / B.
- Pixel order inside an LCU: raster, py = 0..S−1 (outer), px = 0..S−1 (inner).
- Beat acceptance: a beat is accepted at a rising edge where `in_en`=1 and `busy`=0.
- FSM states:
  - IDLE: on `start`, go to LOAD.
  - LOAD: one cycle. Assert `par_rd` with `par_addr`=n, and issue the first `img_rd` of the LCU. Go to STREAM.
  - STREAM:
    - In the first STREAM cycle, capture `par_data` into the parameter outputs. Update `lcu_x`/`lcu_y` in the same cycle.
    - Prefetch pixels into a 2-entry buffer. Issue `img_rd` whenever (buffer occupancy + read in flight − pop this cycle) < 2 and LCU pixels remain to be read.
    - `in_en` = buffer not empty.
    - When the last pixel of the LCU is accepted: if n < B²−1, increment n and go to LOAD; otherwise pulse `done` and go to IDLE.
- Parameter outputs, `lcu_x`, `lcu_y` and `lcu_size` are constant for all beats of an LCU.
- While `busy`=1 with `in_en`=1, `din` and all side outputs hold stable.
- No pixel is ever dropped or duplicated, including when `busy` toggles every cycle.
- `start` outside IDLE is ignored. `start` on the same edge as `done` is ignored.
- `active` is 1 from the edge after `start` is sampled through the `done` cycle inclusive.
- `reset` asserted mid-frame:
  - Return immediately to IDLE.
  - Clear the buffer and the in-flight flag.
  - All outputs go to their reset values.

## Timing
- Reset value of every output is 0.
- Startup: `start` sampled at edge E0. LOAD occupies the cycle after E0. The first `in_en` is high in the cycle after E2.
- Throughput: one pixel per cycle sustained while `busy`=0.
- LCU boundary: `in_en` is low for exactly 2 cycles between the last beat of LCU n and the first beat of LCU n+1, when `busy`=0.
- `done`: high in the cycle after the edge that accepts pixel 16383.
- Frame duration with `busy`=0: for code 2, 16384 + 2·4 cycles from the first LOAD to `done`.

## Configuration
- `IPF_FEEDER_RASTER_EN` defined: `img_addr` = (lcu_y·S + py)·128 + lcu_x·S + px. The image is stored raster order.
- `IPF_FEEDER_RASTER_EN` undefined: `img_addr` = n·S² + py·S + px. The image is stored LCU-contiguous, and addresses are linear 0..16383.
- Streaming order, handshake and timing are identical in both builds.

## Structure
- Package `ipf_pkg` holds:
  - `IMG_W`.
  - Size-code constants.
  - Parameter-word field positions.
  - The FSM state enum (IDLE, LOAD, STREAM).
- Sub-module `ipf_feed_fifo`: 2-entry pixel skid buffer with push, pop, occupancy and synchronous clear.
- Address generation and the FSM stay in the top.

## Test plan
- Code 2, `busy`=0, linear build, image[k] = k[7:0]:
  - Expect 16384 beats with `din` = k[7:0] in order.
  - `lcu_x`/`lcu_y` sequence (0,0),(1,0),(0,1),(1,1).
  - `done` exactly once.
- Raster build, code 2: first beat of LCU 1 reads `img_addr` 64; first beat of LCU 2 reads 8192; last beat of the frame reads 16383.
- Code 0: 64 LCUs, `par_addr` 0..63. LCU 63 has `lcu_x`=7, `lcu_y`=7. Parameter word 0xC2_1234 gives type 3, band_pos 1, wo_class 0, offset 0x1234.
- `busy` pseudo-random at 50%:
  - Pixel sequence identical to the `busy`=0 run.
  - `din` stable across every stalled edge.
  - `busy` held high for 10 cycles produces no image reads beyond 2 buffered.
- `reset` pulled low mid-LCU 1:
  - All outputs 0 within the same cycle.
  - A subsequent `start` restarts at n=0, pixel 0.
- Code 3: behaves identically to code 2, with `lcu_size` output = 3.
